// File: rtl/gcn_phase_scheduler.sv
// Pass sequencer for one GCN inference: clear, transform, combine, argmax.
// Each phase has a start/sticky-done handshake and a shared per-phase timeout.
module gcn_phase_scheduler #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES + 1),
    parameter int CYCLE_WIDTH    = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   transform_done,
    input  logic                   combine_done,
    input  logic                   argmax_done,
    output logic                   sub_clear,
    output logic                   start_transform,
    output logic                   start_combine,
    output logic                   start_argmax,
    output logic [1:0]             mem_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             error_phase,
    output logic [CYCLE_WIDTH-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_TRANSFORM = 3'd2,
        S_COMBINE   = 3'd3,
        S_ARGMAX    = 3'd4,
        S_FINISH    = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic [1:0]             err_phase_q, err_phase_d;

    logic       phase_active;
    logic       phase_done;
    logic [1:0] phase_idx;
    state_t     phase_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            cycle_q     <= '0;
            err_phase_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cycle_q     <= cycle_d;
            err_phase_q <= err_phase_d;
        end
    end

    // Only the active phase's done is looked at; the others are ignored.
    always_comb begin
        phase_active = 1'b0;
        phase_done   = 1'b0;
        phase_idx    = 2'd0;
        phase_next   = S_IDLE;
        case (state_q)
            S_TRANSFORM: begin
                phase_active = 1'b1;
                phase_done   = transform_done;
                phase_idx    = 2'd0;
                phase_next   = S_COMBINE;
            end
            S_COMBINE: begin
                phase_active = 1'b1;
                phase_done   = combine_done;
                phase_idx    = 2'd1;
                phase_next   = S_ARGMAX;
            end
            S_ARGMAX: begin
                phase_active = 1'b1;
                phase_done   = argmax_done;
                phase_idx    = 2'd2;
                phase_next   = S_FINISH;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cycle_d     = cycle_q;
        err_phase_d = err_phase_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CLEAR;
                    cycle_d     = '0;
                    err_phase_d = 2'd0;
                end
            end
            S_CLEAR: begin
                state_d = S_TRANSFORM;
                timer_d = '0;
            end
            S_TRANSFORM, S_COMBINE, S_ARGMAX: begin
                if (cycle_q != {CYCLE_WIDTH{1'b1}}) begin
                    cycle_d = cycle_q + 1'b1;
                end
                timer_d = timer_q + 1'b1;
                // A done arriving on the last allowed cycle still counts as success.
                if (phase_done) begin
                    state_d = phase_next;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d     = S_ERROR;
                    err_phase_d = phase_idx;
                end
            end
            S_FINISH, S_ERROR: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sub-controllers are held in clear while our own reset is asserted.
    always_comb begin
        sub_clear       = reset || (state_q == S_CLEAR);
        start_transform = (state_q == S_TRANSFORM);
        start_combine   = (state_q == S_COMBINE);
        start_argmax    = (state_q == S_ARGMAX);
        busy            = (state_q == S_CLEAR) || phase_active;
        done            = (state_q == S_FINISH);
        error           = (state_q == S_ERROR);
        mem_sel         = 2'd0;
        if (state_q == S_COMBINE) begin
            mem_sel = 2'd1;
        end else if (state_q == S_ARGMAX) begin
            mem_sel = 2'd2;
        end
    end

    assign error_phase = err_phase_q;
    assign cycle_count = cycle_q;

endmodule
